seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
- Shares the single 16-bit hex display data input of the LED7Seg driver between NREQ requesters (CPU debug registers, PC, status words).
- Each requester writes a 16-bit value into its own shadow register.
- The scheduler rotates round-robin over valid shadows, holding each for HOLD_CYCLES. A pin override locks one source for debugging.
- Sits between the datapath/debug logic and the LED7Seg data port.

Parameters:
- NREQ, 4: number of requesters (2..8).
- SEL_W, 2: index width, equal to clog2(NREQ).
- HOLD_CYCLES, 50000000: display dwell per source, in clk cycles (≥2).
- CNT_W, 26: hold counter width; 2^CNT_W must be > HOLD_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr  in  NREQ  write strobe per requester; one bit per cycle per requester
- clr  in  NREQ  invalidate strobe per requester
- wdata  in  16*NREQ  write data; requester i uses bits [16i+15:16i]
- ack  out  NREQ  one-cycle pulse: write accepted
- pin_en  in  1  force display of pin_sel
- pin_sel  in  SEL_W  pinned source index
- data_out  out  16  value to LED7Seg data input
- cur_sel  out  SEL_W  index currently displayed
- active  out  1  high when data_out shows a valid or pinned source

Behaviour:
- Reset, sampled on the clk edge, clears:
  - all shadows to 16'h0000 and all valid bits to 0;
  - cur_sel to 0, hold counter to 0, ack to 0;
  - data_out to 16'h0000, active to 0;
  - state to IDLE.
- Reset asserted mid-hold aborts the rotation immediately.
- Writes:
  - wr[i] at edge N loads shadow[i] from its wdata slice and sets valid[i].
  - ack[i] is high exactly in cycle N+1.
  - Writes are always accepted; there is no backpressure.
- Clears: clr[i] resets valid[i]; the shadow value is kept.
  - wr[i] and clr[i] in the same cycle: the write wins (valid stays 1, ack pulses).
- Output timing:
  - data_out is registered: data_out = shadow[cur_sel] one cycle after either one changes.
  - A write to the displayed source appears on data_out 2 cycles after the wr edge.
  - active is registered alongside data_out.
- States:
  - IDLE: no valid bit set and pin_en=0.
    - data_out keeps its last value; active=0; counter held at 0.
    - Any valid bit set → SHOW, with cur_sel = lowest valid index and counter = 0.
  - SHOW: counter increments each cycle.
    - When counter == HOLD_CYCLES-1 → ADVANCE.
    - valid[cur_sel] cleared → ADVANCE next cycle without waiting for the hold.
  - ADVANCE (one cycle): pick the first valid index searching cur_sel+1, cur_sel+2, … modulo NREQ (wraps past NREQ-1 to 0).
    - If the only valid index is cur_sel: keep it, counter = 0 → SHOW.
    - If no index is valid → IDLE.
  - PIN: entered from any state when pin_en=1.
    - cur_sel = pin_sel, re-read each cycle, so pin_sel changes take effect after one cycle.
    - Counter held at 0; active=1 regardless of the valid bit.
    - Writes and clears still update shadows and valid bits.
    - pin_en falling → SHOW at pin_sel with counter = 0 (full hold) if valid[pin_sel]; otherwise → ADVANCE.
- pin_sel ≥ NREQ (when NREQ is not a power of 2): treated as index 0.
- Counter never wraps: it is bounded by HOLD_CYCLES-1 and reset on every source change.

Test Plan (HOLD_CYCLES=4, NREQ=4):
- Reset: assert reset for 2 cycles mid-rotation → data_out=0000, cur_sel=0, active=0, ack=0 in the cycle after reset deasserts.
- Rotation and wrap:
  - wr sources 0,1,3 with 1111, 2222, 3333.
  - Expected: data_out cycles 1111→2222→3333→1111, index 2 is skipped, each shown 4 cycles plus 1 ADVANCE cycle.
  - ack pulses one cycle after each wr.
- Single source: only source 2 written (ABCD) → cur_sel stays 2, data_out stays ABCD indefinitely, active=1.
- Clear while displayed:
  - clr the current source mid-hold → advance to the next valid source within 2 cycles.
  - Clear all sources → IDLE, active=0, data_out holds its last value.
- Simultaneous and live update:
  - wr[1] with clr[1] in the same cycle → valid[1] stays 1, ack[1]=1.
  - wr to the displayed source with BEEF → data_out=BEEF 2 cycles later, with no change to the rotation timing.
- Pin override:
  - pin_en=1, pin_sel=2 while source 2 is invalid → cur_sel=2, active=1, no rotation for 20 cycles.
  - Release pin_en → ADVANCE to the next valid source after 2.
  - Repeat with source 2 valid → source 2 is shown for a full 4-cycle hold after release.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing one 16-bit hex display input between NREQ
// requesters, each with its own shadow register, plus a pin override for debug.
module seg_display_scheduler #(
  parameter int NREQ        = 4,
  parameter int SEL_W       = 2,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      wr,
  input  logic [NREQ-1:0]      clr,
  input  logic [16*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  input  logic                 pin_en,
  input  logic [SEL_W-1:0]     pin_sel,
  output logic [15:0]          data_out,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 active
);

  typedef enum logic [1:0] {IDLE, SHOW, ADVANCE, PIN} state_t;

  state_t           state;
  logic [15:0]      shadow [NREQ];
  logic [NREQ-1:0]  valid;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] pin_idx;
  logic [SEL_W-1:0] low_idx;
  logic [SEL_W-1:0] next_idx;
  logic             low_found;
  logic             next_found;

  // Out-of-range pin indices (non power-of-two NREQ) fall back to source 0.
  always_comb begin
    pin_idx = (int'(pin_sel) < NREQ) ? pin_sel : '0;
  end

  // Lowest valid index, and first valid index after cur_sel with wrap-around;
  // the last probe lands on cur_sel itself so a lone source is kept.
  always_comb begin
    int unsigned      j;
    logic [SEL_W-1:0] jsel;
    low_idx    = '0;
    low_found  = 1'b0;
    next_idx   = cur_sel;
    next_found = 1'b0;
    j          = 0;
    jsel       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!low_found && valid[SEL_W'(k)]) begin
        low_found = 1'b1;
        low_idx   = SEL_W'(k);
      end
    end
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j    = (32'(cur_sel) + k) % NREQ;
      jsel = SEL_W'(j);
      if (!next_found && valid[jsel]) begin
        next_found = 1'b1;
        next_idx   = jsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) shadow[i] <= '0;
      valid    <= '0;
      ack      <= '0;
      state    <= IDLE;
      cur_sel  <= '0;
      cnt      <= '0;
      data_out <= '0;
      active   <= 1'b0;
    end else begin
      ack <= wr;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (wr[i]) begin
          shadow[i] <= wdata[16*i +: 16];
          valid[i]  <= 1'b1;
        end else if (clr[i]) begin
          valid[i]  <= 1'b0;
        end
      end

      // In IDLE the display freezes on whatever it last showed.
      if (state == IDLE) begin
        active <= 1'b0;
      end else begin
        data_out <= shadow[cur_sel];
        active   <= 1'b1;
      end

      if (pin_en) begin
        state   <= PIN;
        cur_sel <= pin_idx;
        cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (low_found) begin
              state   <= SHOW;
              cur_sel <= low_idx;
            end
          end
          SHOW: begin
            if (!valid[cur_sel] || cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              state <= ADVANCE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ADVANCE: begin
            cnt <= '0;
            if (next_found) begin
              state   <= SHOW;
              cur_sel <= next_idx;
            end else begin
              state <= IDLE;
            end
          end
          PIN: begin
            cnt     <= '0;
            cur_sel <= pin_idx;
            state   <= valid[pin_idx] ? SHOW : ADVANCE;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed vector table, hand-written pin and
// idle sequences, then random traffic against a dwell-based reference model.
module tb_seg_display_scheduler;

  localparam int NREQ = 4;
  localparam int HOLD = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  wr, clr;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic        pin_en;
  logic [1:0]  pin_sel;
  logic [15:0] data_out;
  logic [1:0]  cur_sel;
  logic        active;

  int total = 0;
  int bad   = 0;

  seg_display_scheduler #(
    .NREQ(NREQ), .SEL_W(2), .HOLD_CYCLES(HOLD), .CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .clr(clr), .wdata(wdata), .ack(ack),
    .pin_en(pin_en), .pin_sel(pin_sel), .data_out(data_out),
    .cur_sel(cur_sel), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a source is shown for HOLD cycles counted down in
  // m_left, then one stepping cycle picks the next valid source.
  typedef enum {M_IDLE, M_SHOW, M_STEP, M_PIN} mmode_t;
  mmode_t      m_mode;
  logic [15:0] m_sh [4];
  logic [3:0]  m_val;
  int          m_sel, m_left;
  logic [15:0] m_do;
  logic        m_act;
  logic [3:0]  m_ack;

  function automatic int next_from(input int s);
    for (int k = 1; k <= NREQ; k++)
      if (m_val[(s + k) % NREQ]) return (s + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int nxt, ps;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_sh[i] = 16'h0000;
      m_val = '0; m_sel = 0; m_left = 0; m_mode = M_IDLE;
      m_do = 16'h0000; m_act = 1'b0; m_ack = '0;
    end else begin
      if (m_mode != M_IDLE) begin m_do = m_sh[m_sel]; m_act = 1'b1; end
      else m_act = 1'b0;
      m_ack = wr;
      ps = (int'(pin_sel) < NREQ) ? int'(pin_sel) : 0;
      if (pin_en) begin
        m_mode = M_PIN; m_sel = ps;
      end else begin
        case (m_mode)
          M_IDLE: begin
            nxt = next_from(-1);
            if (nxt >= 0) begin m_sel = nxt; m_mode = M_SHOW; m_left = HOLD; end
          end
          M_SHOW: begin
            if (!m_val[m_sel] || m_left == 1) m_mode = M_STEP;
            else m_left = m_left - 1;
          end
          M_STEP: begin
            nxt = next_from(m_sel);
            if (nxt < 0) m_mode = M_IDLE;
            else begin m_sel = nxt; m_mode = M_SHOW; m_left = HOLD; end
          end
          M_PIN: begin
            m_sel = ps;
            if (m_val[ps]) begin m_mode = M_SHOW; m_left = HOLD; end
            else m_mode = M_STEP;
          end
          default: m_mode = M_IDLE;
        endcase
      end
      for (int i = 0; i < 4; i++) begin
        if (wr[i]) begin m_sh[i] = wdata[16*i +: 16]; m_val[i] = 1'b1; end
        else if (clr[i]) m_val[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  wr, clr;
    logic [63:0] wdata;
    logic [15:0] e_do;
    logic [1:0]  e_sel;
    logic        e_act;
    logic [3:0]  e_ack;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [3:0] w, input logic [3:0] c,
                             input logic [63:0] d, input logic [15:0] edo,
                             input logic [1:0] es, input logic ea, input logic [3:0] ek);
    vec_t t;
    t.rst = r; t.wr = w; t.clr = c; t.wdata = d;
    t.e_do = edo; t.e_sel = es; t.e_act = ea; t.e_ack = ek;
    return t;
  endfunction

  vec_t tbl [25];

  initial begin
    reset = 1'b1; wr = '0; clr = '0; wdata = '0; pin_en = 1'b0; pin_sel = '0;

    // Rotation over 0,1,3 with 2 skipped, simultaneous wr/clr on 1, clear of 3.
    tbl[0]  = v(1, 4'h0, 4'h0, 64'h0,                   16'h0000, 0, 0, 4'h0);
    tbl[1]  = v(1, 4'h0, 4'h0, 64'h0,                   16'h0000, 0, 0, 4'h0);
    tbl[2]  = v(0, 4'h1, 4'h0, 64'h0000_0000_0000_1111, 16'h0000, 0, 0, 4'h1);
    tbl[3]  = v(0, 4'h2, 4'h0, 64'h0000_0000_2222_0000, 16'h0000, 0, 0, 4'h2);
    tbl[4]  = v(0, 4'h8, 4'h0, 64'h3333_0000_0000_0000, 16'h1111, 0, 1, 4'h8);
    tbl[5]  = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[6]  = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[7]  = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[8]  = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 1, 1, 4'h0);
    tbl[9]  = v(0, 4'h0, 4'h0, 64'h0,                   16'h2222, 1, 1, 4'h0);
    tbl[10] = v(0, 4'h0, 4'h0, 64'h0,                   16'h2222, 1, 1, 4'h0);
    tbl[11] = v(0, 4'h0, 4'h0, 64'h0,                   16'h2222, 1, 1, 4'h0);
    tbl[12] = v(0, 4'h0, 4'h0, 64'h0,                   16'h2222, 1, 1, 4'h0);
    tbl[13] = v(0, 4'h0, 4'h0, 64'h0,                   16'h2222, 3, 1, 4'h0);
    tbl[14] = v(0, 4'h0, 4'h0, 64'h0,                   16'h3333, 3, 1, 4'h0);
    tbl[15] = v(0, 4'h2, 4'h2, 64'h0000_0000_4444_0000, 16'h3333, 3, 1, 4'h2);
    tbl[16] = v(0, 4'h0, 4'h8, 64'h0,                   16'h3333, 3, 1, 4'h0);
    tbl[17] = v(0, 4'h0, 4'h0, 64'h0,                   16'h3333, 3, 1, 4'h0);
    tbl[18] = v(0, 4'h0, 4'h0, 64'h0,                   16'h3333, 0, 1, 4'h0);
    tbl[19] = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[20] = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[21] = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[22] = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 0, 1, 4'h0);
    tbl[23] = v(0, 4'h0, 4'h0, 64'h0,                   16'h1111, 1, 1, 4'h0);
    tbl[24] = v(0, 4'h0, 4'h0, 64'h0,                   16'h4444, 1, 1, 4'h0);

    for (int i = 0; i < 25; i++) begin
      reset = tbl[i].rst; wr = tbl[i].wr; clr = tbl[i].clr; wdata = tbl[i].wdata;
      step();
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(tbl[i].e_do));
      chk($sformatf("vec%0d.cur_sel", i),  32'(cur_sel),  32'(tbl[i].e_sel));
      chk($sformatf("vec%0d.active", i),   32'(active),   32'(tbl[i].e_act));
      chk($sformatf("vec%0d.ack", i),      32'(ack),      32'(tbl[i].e_ack));
    end
    wr = '0; clr = '0; wdata = '0;

    // Pin an invalid source: no rotation, active forced high.
    pin_en = 1'b1; pin_sel = 2'd2;
    step();
    chk("pin.sel_first", 32'(cur_sel), 32'd2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pin.hold_sel", 32'(cur_sel), 32'd2);
      chk("pin.hold_act", 32'(active), 32'd1);
      chk("pin.hold_do", 32'(data_out), 32'h0000);
    end
    pin_sel = 2'd3;
    step();
    chk("pin.resel", 32'(cur_sel), 32'd3);
    pin_sel = 2'd2;
    step();
    pin_en = 1'b0;
    step();
    chk("unpin_invalid.adv", 32'(cur_sel), 32'd2);
    step();
    chk("unpin_invalid.next", 32'(cur_sel), 32'd0);

    // Pin a valid source: full hold after release.
    wr = 4'h4; wdata = 64'h0000_5555_0000_0000;
    step();
    wr = '0;
    pin_en = 1'b1; pin_sel = 2'd2;
    step();
    step();
    pin_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("unpin_valid.sel%0d", i), 32'(cur_sel), 32'd2);
      chk($sformatf("unpin_valid.do%0d", i), 32'(data_out), 32'h5555);
    end
    step();
    chk("unpin_valid.after", 32'(cur_sel), 32'd0);

    // Single source, live update, then clear everything into IDLE.
    reset = 1'b1; step(); reset = 1'b0;
    wr = 4'h4; wdata = 64'h0000_ABCD_0000_0000;
    step();
    wr = '0;
    for (int i = 0; i < 15; i++) step();
    chk("single.sel", 32'(cur_sel), 32'd2);
    chk("single.do", 32'(data_out), 32'hABCD);
    chk("single.act", 32'(active), 32'd1);
    wr = 4'h4; wdata = 64'h0000_BEEF_0000_0000;
    step();
    wr = '0;
    chk("live.not_yet", 32'(data_out), 32'hABCD);
    step();
    chk("live.beef", 32'(data_out), 32'hBEEF);
    clr = 4'h4;
    step();
    clr = '0;
    for (int i = 0; i < 4; i++) step();
    chk("idle.act", 32'(active), 32'd0);
    chk("idle.do_hold", 32'(data_out), 32'hBEEF);

    // Random traffic against the reference model.
    reset = 1'b1; step(); reset = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        wr[i]  = ($urandom_range(0, 7) == 0);
        clr[i] = ($urandom_range(0, 15) == 0);
      end
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) pin_en = ~pin_en;
      if ($urandom_range(0, 9) == 0) pin_sel = 2'($urandom_range(0, 3));
      step();
      chk("rnd.data_out", 32'(data_out), 32'(m_do));
      chk("rnd.cur_sel",  32'(cur_sel),  32'(m_sel));
      chk("rnd.active",   32'(active),   32'(m_act));
      chk("rnd.ack",      32'(ack),      32'(m_ack));
    end

    // Reset mid-rotation for two cycles.
    wr = 4'hB; clr = '0; pin_en = 1'b0; wdata = 64'h7777_6666_5555_4444;
    step();
    wr = '0;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst.data_out", 32'(data_out), 32'h0000);
    chk("rst.cur_sel",  32'(cur_sel),  32'd0);
    chk("rst.active",   32'(active),   32'd0);
    chk("rst.ack",      32'(ack),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
